// File: rtl/pipe_pkg.sv
// Shared types for the decode-to-execute pipeline boundary.
package pipe_pkg;

  // Packed control bundle as carried from decode into execute.
  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] aluop;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Occupancy of the stage: nothing, main register only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded payload register with asynchronous clear; used for both the
// main (output) register and the skid register of the stage.
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load the whole bundle when enabled, otherwise hold.
  // NOTE: payload storage is cleared on reset so the stage never presents
  // X data after power-up, even though ctrl gating would hide it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Decode-to-execute pipeline stage with valid/ready handshake, a one-entry
// skid behind the output register, synchronous flush and a saturating
// downstream-stall counter.
module pipe_stage_skid #(
  parameter int DATA_W      = 64,
  parameter int REG_ADDR_W  = 5,
  parameter int CTRL_W      = pipe_pkg::CTRL_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      ctrl_in,
  input  logic [DATA_W-1:0]      rs1Data_in,
  input  logic [DATA_W-1:0]      rs2Data_in,
  input  logic [REG_ADDR_W-1:0]  rs_in,
  input  logic [REG_ADDR_W-1:0]  rt_in,
  input  logic [REG_ADDR_W-1:0]  rd_in,
  input  logic [DATA_W-1:0]      immediate_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      ctrl_out,
  output logic [DATA_W-1:0]      rs1Data_out,
  output logic [DATA_W-1:0]      rs2Data_out,
  output logic [REG_ADDR_W-1:0]  rs_out,
  output logic [REG_ADDR_W-1:0]  rt_out,
  output logic [REG_ADDR_W-1:0]  rd_out,
  output logic [DATA_W-1:0]      immediate_out,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  import pipe_pkg::skid_state_t;
  import pipe_pkg::EMPTY;
  import pipe_pkg::FULL;
  import pipe_pkg::SKID;

  localparam int PAY_W = CTRL_W + 3 * DATA_W + 3 * REG_ADDR_W;

  skid_state_t      state, state_d;
  logic             load_main, load_skid, main_from_skid;
  logic [PAY_W-1:0] in_pay, skid_q, main_d, main_q;
  logic [CTRL_W-1:0] ctrl_q;

  assign in_pay = {ctrl_in, rs1Data_in, rs2Data_in, rs_in, rt_in, rd_in, immediate_in};
  assign main_d = main_from_skid ? skid_q : in_pay;

  pipe_payload_reg #(.W(PAY_W)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (load_main),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_payload_reg #(.W(PAY_W)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (load_skid),
    .d   (in_pay),
    .q   (skid_q)
  );

  assign {ctrl_q, rs1Data_out, rs2Data_out, rs_out, rt_out, rd_out, immediate_out} = main_q;

  // Handshake outputs are pure decodes of the state register, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready  = (state != SKID);
  assign out_valid = (state == FULL) || (state == SKID);
  assign ctrl_out  = ctrl_q & {CTRL_W{out_valid}};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and load decisions; flush overrides every transfer.
  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            load_main = 1'b1;
            state_d   = FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_valid) load_main = 1'b1;
            else          state_d   = EMPTY;
          end else if (in_valid) begin
            load_skid = 1'b1;
            state_d   = SKID;
          end
        end
        SKID: begin
          if (out_ready) begin
            load_main      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Count cycles where downstream refuses a valid bundle; stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
